// File: rtl/bc_game_controller_if.sv
// Port bundle for the Bulls & Cows game sequencer: the confirm/code inputs and the
// game status outputs consumed by the display manager.
interface bc_game_controller_if #(
    parameter int ROUND_W = 8
);
    logic               confirm;
    logic [15:0]        code_in;
    logic [2:0]         state;
    logic [2:0]         bulls;
    logic [2:0]         cows;
    logic               code_err;
    logic               guesser;
    logic [ROUND_W-1:0] round_cnt;

    modport master (
        output confirm,
        output code_in,
        input  state,
        input  bulls,
        input  cows,
        input  code_err,
        input  guesser,
        input  round_cnt
    );

    modport slave (
        input  confirm,
        input  code_in,
        output state,
        output bulls,
        output cows,
        output code_err,
        output guesser,
        output round_cnt
    );
endinterface

// File: rtl/bc_game_controller.sv
// Bulls & Cows game sequencer: secret/guess capture, scoring, turn alternation and winner.
// Optional confirm debouncer is enabled by defining BC_DEBOUNCE_EN.
//
// state          | meaning
// IDLE           | waiting for a confirm to start a game
// SECRET_J1      | player 1 enters a secret
// SECRET_J2      | player 2 enters a secret
// GUESS_J1       | player 1 guesses player 2's secret
// GUESS_J2       | player 2 guesses player 1's secret
// WIN_J1         | player 1 found 4 bulls
// WIN_J2         | player 2 found 4 bulls
// DISPLAY_RESULT | showing bulls/cows of the last guess
module bc_game_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ROUND_W         = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    bc_game_controller_if.slave     bus_if
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SECRET_J1 = 3'd1,
        S_SECRET_J2 = 3'd2,
        S_GUESS_J1  = 3'd3,
        S_GUESS_J2  = 3'd4,
        S_WIN_J1    = 3'd5,
        S_WIN_J2    = 3'd6,
        S_DISPLAY   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        secret1_q, secret1_d;
    logic [15:0]        secret2_q, secret2_d;
    logic [2:0]         bulls_q, bulls_d;
    logic [2:0]         cows_q, cows_d;
    logic               code_err_q, code_err_d;
    logic               guesser_q, guesser_d;
    logic [ROUND_W-1:0] round_q, round_d;

    logic               level;
    logic               prev_q;
    logic               tick;

`ifdef BC_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            db_q;
    logic [DB_W-1:0] db_cnt_q;

    // Down-counter restarts whenever the synchronised input agrees with the
    // debounced level, so only an unbroken run of differing samples flips it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_cnt_q <= DB_RELOAD;
        end else begin
            sync1_q <= bus_if.confirm;
            sync2_q <= sync1_q;
            if (sync2_q == db_q) begin
                db_cnt_q <= DB_RELOAD;
            end else if (db_cnt_q == '0) begin
                db_q     <= sync2_q;
                db_cnt_q <= DB_RELOAD;
            end else begin
                db_cnt_q <= db_cnt_q - 1'b1;
            end
        end
    end

    assign level = db_q;
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES != 0);
    assign level = bus_if.confirm;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign tick = level & ~prev_q;

    function automatic logic code_valid(input logic [15:0] c);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c[i*4 +: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < 4; j++) begin
                if (c[i*4 +: 4] == c[j*4 +: 4]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Returns {bulls, cows}; digit order is irrelevant as long as both sides share it.
    function automatic logic [5:0] score(input logic [15:0] g, input logic [15:0] s);
        logic [2:0] b;
        logic [2:0] c;
        b = 3'd0;
        c = 3'd0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (g[i*4 +: 4] == s[j*4 +: 4]) begin
                    if (i == j) b = b + 3'd1;
                    else        c = c + 3'd1;
                end
            end
        end
        return {b, c};
    endfunction

    logic        valid;
    logic [15:0] opp_secret;
    logic [5:0]  result;

    assign valid      = code_valid(bus_if.code_in);
    assign opp_secret = (state_q == S_GUESS_J1) ? secret2_q : secret1_q;
    assign result     = score(bus_if.code_in, opp_secret);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            secret1_q  <= '0;
            secret2_q  <= '0;
            bulls_q    <= '0;
            cows_q     <= '0;
            code_err_q <= 1'b0;
            guesser_q  <= 1'b0;
            round_q    <= '0;
        end else begin
            state_q    <= state_d;
            secret1_q  <= secret1_d;
            secret2_q  <= secret2_d;
            bulls_q    <= bulls_d;
            cows_q     <= cows_d;
            code_err_q <= code_err_d;
            guesser_q  <= guesser_d;
            round_q    <= round_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        secret1_d  = secret1_q;
        secret2_d  = secret2_q;
        bulls_d    = bulls_q;
        cows_d     = cows_q;
        code_err_d = code_err_q;
        guesser_d  = guesser_q;
        round_d    = round_q;

        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_SECRET_J1;
            end
            S_SECRET_J1: begin
                if (tick) begin
                    if (valid) begin
                        secret1_d  = bus_if.code_in;
                        code_err_d = 1'b0;
                        state_d    = S_SECRET_J2;
                    end else begin
                        code_err_d = 1'b1;
                    end
                end
            end
            S_SECRET_J2: begin
                if (tick) begin
                    if (valid) begin
                        secret2_d  = bus_if.code_in;
                        code_err_d = 1'b0;
                        state_d    = S_GUESS_J1;
                    end else begin
                        code_err_d = 1'b1;
                    end
                end
            end
            S_GUESS_J1: begin
                if (tick) begin
                    if (valid) begin
                        bulls_d    = result[5:3];
                        cows_d     = result[2:0];
                        guesser_d  = 1'b0;
                        code_err_d = 1'b0;
                        state_d    = (result[5:3] == 3'd4) ? S_WIN_J1 : S_DISPLAY;
                    end else begin
                        code_err_d = 1'b1;
                    end
                end
            end
            S_GUESS_J2: begin
                if (tick) begin
                    if (valid) begin
                        bulls_d    = result[5:3];
                        cows_d     = result[2:0];
                        guesser_d  = 1'b1;
                        code_err_d = 1'b0;
                        if (round_q != '1) round_d = round_q + 1'b1;
                        state_d    = (result[5:3] == 3'd4) ? S_WIN_J2 : S_DISPLAY;
                    end else begin
                        code_err_d = 1'b1;
                    end
                end
            end
            S_DISPLAY: begin
                if (tick) state_d = guesser_q ? S_GUESS_J1 : S_GUESS_J2;
            end
            S_WIN_J1, S_WIN_J2: begin
                if (tick) begin
                    state_d   = S_IDLE;
                    secret1_d = '0;
                    secret2_d = '0;
                    bulls_d   = '0;
                    cows_d    = '0;
                    round_d   = '0;
                    guesser_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) code_err_d = 1'b0;
    end

    assign bus_if.state     = state_q;
    assign bus_if.bulls     = bulls_q;
    assign bus_if.cows      = cows_q;
    assign bus_if.code_err  = code_err_q;
    assign bus_if.guesser   = guesser_q;
    assign bus_if.round_cnt = round_q;

endmodule

// File: tb/tb_bc_game_controller.sv
// Directed bench for bc_game_controller; define BC_DEBOUNCE_EN to also exercise the debouncer.
module tb_bc_game_controller;

`ifdef BC_DEBOUNCE_EN
    localparam int TB_DB = 8;
    localparam int HOLD  = 20;
`else
    localparam int TB_DB = 1_000_000;
    localparam int HOLD  = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    bc_game_controller_if #(.ROUND_W(8)) bus ();

    bc_game_controller #(
        .DEBOUNCE_CYCLES (TB_DB),
        .ROUND_W         (8)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after press and release.
    task automatic press(input logic [15:0] code);
        bus.code_in = code;
        bus.confirm = 1'b1;
        repeat (HOLD) @(negedge clk);
        bus.confirm = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    initial begin
        bus.confirm = 1'b0;
        bus.code_in = 16'h0000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state",    16'(bus.state), 16'd0);
        check("rst_bulls",    16'(bus.bulls), 16'd0);
        check("rst_cows",     16'(bus.cows), 16'd0);
        check("rst_code_err", 16'(bus.code_err), 16'd0);
        check("rst_guesser",  16'(bus.guesser), 16'd0);
        check("rst_round",    16'(bus.round_cnt), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Game 1: secrets 1234 / 5678
        press(16'h0000);
        check("idle_to_s1", 16'(bus.state), 16'd1);
        press(16'h1234);
        check("s1_to_s2", 16'(bus.state), 16'd2);
        press(16'h5678);
        check("s2_to_g1", 16'(bus.state), 16'd3);
        check("s2_err_clear", 16'(bus.code_err), 16'd0);

        press(16'h1123);
        check("g1_bad_stay", 16'(bus.state), 16'd3);
        check("g1_bad_err", 16'(bus.code_err), 16'd1);
        press(16'h8675);
        check("g1_state", 16'(bus.state), 16'd7);
        check("g1_bulls", 16'(bus.bulls), 16'd2);
        check("g1_cows", 16'(bus.cows), 16'd2);
        check("g1_guesser", 16'(bus.guesser), 16'd0);
        check("g1_err_clear", 16'(bus.code_err), 16'd0);
        check("g1_round", 16'(bus.round_cnt), 16'd0);
        press(16'hFFFF);
        check("disp_to_g2", 16'(bus.state), 16'd4);

        press(16'h1234);
        check("g2_win_state", 16'(bus.state), 16'd6);
        check("g2_win_bulls", 16'(bus.bulls), 16'd4);
        check("g2_win_cows", 16'(bus.cows), 16'd0);
        check("g2_win_round", 16'(bus.round_cnt), 16'd1);
        check("g2_win_guesser", 16'(bus.guesser), 16'd1);
        press(16'h0000);
        check("win2_to_idle", 16'(bus.state), 16'd0);
        check("win2_round_clr", 16'(bus.round_cnt), 16'd0);
        check("win2_bulls_clr", 16'(bus.bulls), 16'd0);
        check("win2_guesser_clr", 16'(bus.guesser), 16'd0);

        // Game 2: invalid secrets, then secrets 9876 / 5678
        press(16'h0000);
        check("g2_idle_to_s1", 16'(bus.state), 16'd1);
        press(16'h1123);
        check("dup_stay", 16'(bus.state), 16'd1);
        check("dup_err", 16'(bus.code_err), 16'd1);
        press(16'h12A4);
        check("bcd_stay", 16'(bus.state), 16'd1);
        check("bcd_err", 16'(bus.code_err), 16'd1);
        press(16'h9876);
        check("s1_ok_state", 16'(bus.state), 16'd2);
        check("s1_ok_err", 16'(bus.code_err), 16'd0);
        press(16'h5678);
        check("s2_ok_state", 16'(bus.state), 16'd3);

        press(16'h1234);
        check("miss_state", 16'(bus.state), 16'd7);
        check("miss_bulls", 16'(bus.bulls), 16'd0);
        check("miss_cows", 16'(bus.cows), 16'd0);
        press(16'h0000);
        check("miss_to_g2", 16'(bus.state), 16'd4);

        // Held confirm: J2 guesses 5679 vs 9876 -> 1 bull, 2 cows, single transition
        bus.code_in = 16'h5679;
        bus.confirm = 1'b1;
        repeat (100) @(negedge clk);
        check("hold_state", 16'(bus.state), 16'd7);
        check("hold_bulls", 16'(bus.bulls), 16'd1);
        check("hold_cows", 16'(bus.cows), 16'd2);
        check("hold_round", 16'(bus.round_cnt), 16'd1);
        check("hold_guesser", 16'(bus.guesser), 16'd1);
        bus.confirm = 1'b0;
        repeat (HOLD + 2) @(negedge clk);
        check("hold_release", 16'(bus.state), 16'd7);
        press(16'h0000);
        check("disp_to_g1", 16'(bus.state), 16'd3);

        press(16'h5678);
        check("g1_win_state", 16'(bus.state), 16'd5);
        check("g1_win_bulls", 16'(bus.bulls), 16'd4);
        check("g1_win_guesser", 16'(bus.guesser), 16'd0);
        press(16'h0000);
        check("win1_to_idle", 16'(bus.state), 16'd0);

        // Game 3: reach GUESS_J2 then reset asynchronously
        press(16'h0000);
        press(16'h1234);
        press(16'h4321);
        press(16'h1243);
        check("allcow_state", 16'(bus.state), 16'd7);
        check("allcow_bulls", 16'(bus.bulls), 16'd0);
        check("allcow_cows", 16'(bus.cows), 16'd4);
        press(16'h0000);
        check("pre_rst_state", 16'(bus.state), 16'd4);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 16'(bus.state), 16'd0);
        check("async_rst_cows", 16'(bus.cows), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef BC_DEBOUNCE_EN
        repeat (4) begin
            bus.confirm = 1'b1;
            repeat (3) @(negedge clk);
            bus.confirm = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check("db_glitch", 16'(bus.state), 16'd0);
        bus.confirm = 1'b1;
        repeat (20) @(negedge clk);
        bus.confirm = 1'b0;
        repeat (20) @(negedge clk);
        check("db_press", 16'(bus.state), 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
